// File: rtl/ara_perf_window_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ara_perf_pkg                                                     |
// | Brief   : Shared types and indices for the Ara performance window block.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ara_perf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } perf_state_e;

  localparam int unsigned EvtDcacheMiss = 0;
  localparam int unsigned EvtIcacheMiss = 1;
  localparam int unsigned EvtSbFull     = 2;

  localparam int unsigned RdIdxRuntime  = 0;

endpackage
`default_nettype wire

// File: rtl/ara_perf_window_ctrl_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ara_perf_counter                                                 |
// | Brief   : One live counter plus its snapshot register; saturating with a   |
// |           sticky overflow flag when ARA_PERF_SATURATE_EN is defined.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ara_perf_counter
  import ara_perf_pkg::*;
#(
  parameter int CntWidth = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                en_i,
  input  logic                snap_i,
  output logic [CntWidth-1:0] snap_o,
  output logic                ovf_o
);

  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] r_snap;
  logic [CntWidth-1:0] w_cnt_next;

`ifdef ARA_PERF_SATURATE_EN
  logic r_ovf;
  logic w_ovf_next;

  // An increment attempted at all-ones is swallowed and flagged instead.
  always_comb begin
    w_cnt_next = r_cnt;
    w_ovf_next = r_ovf;
    if (en_i) begin
      if (&r_cnt) begin
        w_ovf_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt + {{(CntWidth-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_next;
    end
  end

  assign ovf_o = r_ovf;
`else
  assign w_cnt_next = r_cnt + {{(CntWidth-1){1'b0}}, en_i};
  assign ovf_o      = 1'b0;
`endif

  // Snapshot captures the pre-increment value; clear overrides everything.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_cnt  <= '0;
      r_snap <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      if (snap_i) begin
        r_snap <= r_cnt;
      end
    end
  end

  assign snap_o = r_snap;

endmodule
`default_nettype wire

// File: rtl/ara_perf_window_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ara_perf_window_ctrl                                             |
// | Brief   : Sequenced measurement window for Ara runtime and event counters, |
// |           with idle-time snapshots and a snapshot read port.               |
// |           Optional macro: ARA_PERF_SATURATE_EN (saturating counters).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ara_perf_window_ctrl
  import ara_perf_pkg::*;
#(
  parameter int NrEvents = 3,
  parameter int CntWidth = 64,
  parameter int IdxWidth = $clog2(NrEvents + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sw_en_i,
  input  logic                clear_i,
  input  logic                acc_req_valid_i,
  input  logic                ara_idle_i,
  input  logic [NrEvents-1:0] event_i,
  input  logic                rd_valid_i,
  input  logic [IdxWidth-1:0] rd_idx_i,
  output logic                rd_ready_o,
  output logic                rdata_valid_o,
  output logic [CntWidth-1:0] rdata_o,
  output logic [1:0]          state_o,
  output logic [NrEvents:0]   ovf_o
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ARMED = ARMED;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]          r_state;
  logic [1:0]          w_state_d;
  logic                r_pending;
  logic                r_rdata_valid;
  logic [CntWidth-1:0] r_rdata;
  logic [CntWidth-1:0] w_rd_mux;
  logic                w_count_en;
  logic                w_quiet;
  logic                w_drain_done;
  logic                w_pend_set;
  logic                w_snap_load;
  logic [CntWidth-1:0] w_snap [NrEvents+1];
  logic [NrEvents:0]   w_ovf;

  assign w_quiet      = ara_idle_i && !acc_req_valid_i;
  assign w_drain_done = (r_state == S_DRAIN) && w_quiet;

  // The dispatch that opens the window is itself the first counted cycle.
  assign w_count_en   = (r_state == S_RUN) || (r_state == S_DRAIN) ||
                        ((r_state == S_ARMED) && sw_en_i && acc_req_valid_i);
  assign w_pend_set   = w_count_en && acc_req_valid_i;
  assign w_snap_load  = !clear_i && ((r_pending && w_quiet) || w_drain_done);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      S_IDLE:  if (sw_en_i) w_state_d = S_ARMED;
      S_ARMED: begin
        if (!sw_en_i) begin
          w_state_d = S_IDLE;
        end else if (acc_req_valid_i) begin
          w_state_d = S_RUN;
        end
      end
      S_RUN:   if (!sw_en_i) w_state_d = S_DRAIN;
      S_DRAIN: begin
        if (w_quiet) begin
          w_state_d = S_IDLE;
        end else if (sw_en_i) begin
          w_state_d = S_RUN;
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  for (genvar i = 0; i <= NrEvents; i++) begin : g_cnt
    logic w_en;
    if (i == RdIdxRuntime) begin : g_runtime
      assign w_en = w_count_en;
    end else begin : g_event
      assign w_en = w_count_en && event_i[i-1];
    end

    ara_perf_counter #(
      .CntWidth (CntWidth)
    ) u_counter (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .en_i    (w_en),
      .snap_i  (w_snap_load),
      .snap_o  (w_snap[i]),
      .ovf_o   (w_ovf[i])
    );
  end

  // Out-of-range indices fall through to zero.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i <= NrEvents; i++) begin
      if (rd_idx_i == IdxWidth'(i)) begin
        w_rd_mux = w_snap[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_pending     <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_state <= w_state_d;
      if (clear_i) begin
        r_pending <= 1'b0;
      end else if (w_pend_set) begin
        r_pending <= 1'b1;
      end else if (w_snap_load) begin
        r_pending <= 1'b0;
      end
      r_rdata_valid <= rd_valid_i;
      if (rd_valid_i) begin
        r_rdata <= w_rd_mux;
      end
    end
  end

  assign rd_ready_o    = !rst_i;
  assign rdata_valid_o = r_rdata_valid;
  assign rdata_o       = r_rdata;
  assign state_o       = r_state;
  assign ovf_o         = w_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ara_perf_window_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ara_perf_window_ctrl                                          |
// | Brief   : Directed plus random bench against a behavioural window model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ara_perf_window_ctrl;

  localparam int NE   = 3;
  localparam int CW   = 8;
  localparam int IW   = 3;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sw_en = 1'b0;
  logic          clr = 1'b0;
  logic          acc = 1'b0;
  logic          idle = 1'b1;
  logic [NE-1:0] ev = '0;
  logic          rd_valid = 1'b0;
  logic [IW-1:0] rd_idx = '0;
  logic          rd_ready;
  logic          rdata_valid;
  logic [CW-1:0] rdata;
  logic [1:0]    state;
  logic [NE:0]   ovf;

  int n_checks = 0;
  int n_errors = 0;

  // Model: state number, live counts, snapshots, read data, flags.
  int          m_state;
  int          m_cnt  [NE+1];
  int          m_snap [NE+1];
  bit          m_pend;
  bit [NE:0]   m_ovf;
  bit          m_rv;
  int          m_rdata;

  always #5 clk = ~clk;

  ara_perf_window_ctrl #(
    .NrEvents (NE),
    .CntWidth (CW),
    .IdxWidth (IW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .sw_en_i         (sw_en),
    .clear_i         (clr),
    .acc_req_valid_i (acc),
    .ara_idle_i      (idle),
    .event_i         (ev),
    .rd_valid_i      (rd_valid),
    .rd_idx_i        (rd_idx),
    .rd_ready_o      (rd_ready),
    .rdata_valid_o   (rdata_valid),
    .rdata_o         (rdata),
    .state_o         (state),
    .ovf_o           (ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bump(input int v, input int k);
`ifdef ARA_PERF_SATURATE_EN
    if (v == MAXV) begin
      m_ovf[k] = 1'b1;
      return v;
    end
    return v + 1;
`else
    if (k < 0) return 0;
    return (v + 1) % (MAXV + 1);
`endif
  endfunction

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_step();
    bit counting, snap;
    int nst;
    if (rst) begin
      m_state = 0; m_pend = 0; m_ovf = '0; m_rv = 0; m_rdata = 0;
      for (int k = 0; k <= NE; k++) begin m_cnt[k] = 0; m_snap[k] = 0; end
      return;
    end
    m_rv = rd_valid;
    if (rd_valid) m_rdata = (int'(rd_idx) <= NE) ? m_snap[rd_idx] : 0;
    counting = (m_state == 2) || (m_state == 3) || (m_state == 1 && sw_en && acc);
    snap = (m_pend && idle && !acc) || (m_state == 3 && idle && !acc);
    case (m_state)
      0:       nst = sw_en ? 1 : 0;
      1:       nst = !sw_en ? 0 : (acc ? 2 : 1);
      2:       nst = sw_en ? 2 : 3;
      default: nst = (idle && !acc) ? 0 : (sw_en ? 2 : 3);
    endcase
    m_state = nst;
    if (clr) begin
      m_pend = 0; m_ovf = '0;
      for (int k = 0; k <= NE; k++) begin m_cnt[k] = 0; m_snap[k] = 0; end
    end else begin
      if (snap) for (int k = 0; k <= NE; k++) m_snap[k] = m_cnt[k];
      if (counting && acc) m_pend = 1;
      else if (snap) m_pend = 0;
      if (counting) begin
        m_cnt[0] = bump(m_cnt[0], 0);
        for (int k = 0; k < NE; k++)
          if (ev[k]) m_cnt[k+1] = bump(m_cnt[k+1], k + 1);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check("state_o", state, m_state);
    check("rd_ready_o", rd_ready, !rst);
    check("rdata_valid_o", rdata_valid, m_rv);
    check("rdata_o", rdata, m_rdata);
    check("ovf_o", ovf, m_ovf);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_read(input int idx);
    rd_valid = 1'b1;
    rd_idx = IW'(idx);
    tick();
    rd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ticks(2);
    check("reset state_o", state, 0);
    check("reset rdata_o", rdata, 0);
    check("reset rdata_valid_o", rdata_valid, 0);
    check("reset ovf_o", ovf, 0);
    rst = 1'b0;

    // Basic window: dispatch at t=10, busy 11..40, idle at 41.
    sw_en = 1'b1; idle = 1'b1;
    ticks(3);
    acc = 1'b1; idle = 1'b0;
    tick();
    acc = 1'b0;
    for (int t = 11; t <= 40; t++) begin
      ev = (t >= 15 && t < 22) ? 3'b010 : 3'b000;
      tick();
    end
    ev = '0; idle = 1'b1;
    tick();
    do_read(0);
    check("basic runtime", rdata, 31);
    check("basic state RUN", state, 2);
    do_read(2);
    check("icache events", rdata, 7);
    do_read(1);
    check("dcache events", rdata, 0);
    do_read(5);
    check("out of range idx", rdata, 0);

    // Read collision with a 31 -> 50 snapshot update at t=60.
    idle = 1'b0;
    ticks(12);
    acc = 1'b1;
    tick();
    acc = 1'b0;
    tick();
    idle = 1'b1;
    do_read(0);
    check("collision old value", rdata, 31);
    do_read(0);
    check("collision new value", rdata, 50);

    // Clear mid-RUN, then disable and drain.
    idle = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k <= NE; k++) begin
      do_read(k);
      check("cleared snapshot", rdata, 0);
    end
    sw_en = 1'b0;
    tick();
    check("drain entered", state, 3);
    ticks(9);
    idle = 1'b1;
    tick();
    check("drain exit IDLE", state, 0);
    ticks(5);
    do_read(0);
    check("drain snapshot", rdata, 14);

    // Reset mid-window.
    sw_en = 1'b1; idle = 1'b0;
    tick();
    acc = 1'b1;
    tick();
    acc = 1'b0;
    ticks(6);
    rst = 1'b1; sw_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("mid-window reset state", state, 0);
    do_read(0);
    check("reset snapshot", rdata, 0);

    // 300 counted cycles into an 8-bit counter.
    sw_en = 1'b1;
    tick();
    acc = 1'b1;
    tick();
    acc = 1'b0;
    ticks(299);
    idle = 1'b1;
    tick();
    do_read(0);
`ifdef ARA_PERF_SATURATE_EN
    check("overflow saturate", rdata, MAXV);
    check("overflow flag", ovf[0], 1);
`else
    check("overflow wrap", rdata, 44);
    check("overflow flag", ovf, 0);
`endif

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) sw_en = ~sw_en;
      acc      = ($urandom_range(0, 7) == 0);
      idle     = $urandom_range(0, 1) == 1;
      ev       = NE'($urandom);
      rd_valid = ($urandom_range(0, 2) == 0);
      rd_idx   = IW'($urandom_range(0, 7));
      clr      = ($urandom_range(0, 63) == 0);
      rst      = ($urandom_range(0, 255) == 0);
      tick();
    end
    rst = 1'b0; clr = 1'b0; rd_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
